dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline MEM stage and a loader/debug port. The two requesters are arbitrated under fixed CPU priority with a starvation guard. Each granted access is sequenced through a registered command, a fixed memory latency and a one-cycle acknowledge. The block sits between the EX/MEM buffer and `data_memory`, and it raises `cpu_stall` to freeze the pipeline while a CPU access is outstanding.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_arb_pick.sv | 24 ++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its winner picker.
package dmem_arb_pkg;

  // Access sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Owner encoding carried on grant_id
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_arb_pick.sv
// Combinational two-requester winner selection: fixed CPU priority, except
// that a saturated starvation count lets a waiting loader through.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic ld_req,
  input  logic starve_sat,
  output logic win,
  output logic pick
);

  // Decide whether anyone is requesting and who gets the next access
  always_comb begin
    win  = cpu_req | ld_req;
    pick = GNT_CPU;
    if (ld_req && (!cpu_req || starve_sat)) begin
      pick = GNT_LD;
    end else begin
      pick = GNT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the pipeline MEM stage (CPU) and a
// loader/debug port. One access at a time: IDLE -> ISSUE -> WAIT x MEM_LAT
// -> DONE, with the owner's ack pulsed in DONE.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [LW-1:0] LAT_ONE    = LW'(1'b1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1'b1);

  arb_state_t    state_r;
  arb_state_t    state_nx_s;
  logic [LW-1:0] lat_cnt_r;
  logic [SW-1:0] starve_cnt_r;
  logic          cmd_we_r;
  logic [AW-1:0] cmd_addr_r;
  logic [DW-1:0] cmd_wdata_r;
  logic          gnt_r;
  logic [DW-1:0] cpu_rdata_r;
  logic [DW-1:0] ld_rdata_r;
  logic          win_s;
  logic          pick_s;
  logic          starve_sat_s;
  logic          lat_done_s;
  logic          grant_now_s;

  assign starve_sat_s = (starve_cnt_r == STARVE_TOP);
  assign lat_done_s   = (lat_cnt_r == LAT_LAST);
  assign grant_now_s  = (state_r == IDLE) && win_s;

  arb_pick u_pick (
    .cpu_req    (cpu_req),
    .ld_req     (ld_req),
    .starve_sat (starve_sat_s),
    .win        (win_s),
    .pick       (pick_s)
  );

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state sequencing of one memory access
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = win_s ? ISSUE : IDLE;
      ISSUE:   state_nx_s = WAIT;
      WAIT:    state_nx_s = lat_done_s ? DONE : WAIT;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Memory strobe and acks decoded from state; command gated to the ISSUE cycle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    cpu_ack   = 1'b0;
    ld_ack    = 1'b0;
    case (state_r)
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = cmd_we_r;
        mem_addr  = cmd_addr_r;
        mem_wdata = cmd_wdata_r;
      end
      DONE: begin
        cpu_ack = (gnt_r == GNT_CPU);
        ld_ack  = (gnt_r == GNT_LD);
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Latch the winner's command and identity when IDLE grants an access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_r       <= GNT_CPU;
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= {AW{1'b0}};
      cmd_wdata_r <= {DW{1'b0}};
    end else if (grant_now_s) begin
      gnt_r       <= pick_s;
      cmd_we_r    <= (pick_s == GNT_LD) ? ld_we    : cpu_we;
      cmd_addr_r  <= (pick_s == GNT_LD) ? ld_addr  : cpu_addr;
      cmd_wdata_r <= (pick_s == GNT_LD) ? ld_wdata : cpu_wdata;
    end
  end

  // Count contested CPU wins; a loader grant or an uncontested CPU win clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (grant_now_s) begin
      if (pick_s == GNT_LD || !ld_req) begin
        starve_cnt_r <= {SW{1'b0}};
      end else if (!starve_sat_s) begin
        starve_cnt_r <= starve_cnt_r + STARVE_ONE;
      end
    end
  end

  // Memory latency counter: restarts on ISSUE, advances through WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt_r <= {LW{1'b0}};
    end else if (state_r == ISSUE) begin
      lat_cnt_r <= {LW{1'b0}};
    end else if (state_r == WAIT && !lat_done_s) begin
      lat_cnt_r <= lat_cnt_r + LAT_ONE;
    end
  end

  // Capture read data for the owner on the last WAIT cycle; writes leave it alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_r <= {DW{1'b0}};
      ld_rdata_r  <= {DW{1'b0}};
    end else if (state_r == WAIT && lat_done_s && !cmd_we_r) begin
      if (gnt_r == GNT_LD) begin
        ld_rdata_r <= mem_rdata;
      end else begin
        cpu_rdata_r <= mem_rdata;
      end
    end
  end

  assign cpu_rdata = cpu_rdata_r;
  assign ld_rdata  = ld_rdata_r;
  assign busy      = (state_r != IDLE);
  assign grant_id  = gnt_r;
  assign cpu_stall = rst & cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: MEM_LAT=1 instance for arbitration,
// timing and data paths; MEM_LAT=3 instance for reset during WAIT.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic        rst, cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ld_req, ld_we, ld_ack;
  logic [15:0] ld_addr, ld_wdata, ld_rdata;
  logic        mem_en, mem_we, busy, grant_id;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT = 3 instance
  logic        rst3, c3_req, c3_we, c3_ack, c3_stall;
  logic [15:0] c3_addr, c3_wdata, c3_rdata;
  logic        l3_req, l3_we, l3_ack;
  logic [15:0] l3_addr, l3_wdata, l3_rdata;
  logic        m3_en, m3_we, busy3, gid3;
  logic [15:0] m3_addr, m3_wdata, m3_rdata;

  dmem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  dmem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst3),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_rdata(c3_rdata), .cpu_ack(c3_ack), .cpu_stall(c3_stall),
    .ld_req(l3_req), .ld_we(l3_we), .ld_addr(l3_addr), .ld_wdata(l3_wdata),
    .ld_rdata(l3_rdata), .ld_ack(l3_ack),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .busy(busy3), .grant_id(gid3)
  );

  // Power-on memory contents
  function automatic logic [15:0] pat(input logic [7:0] a);
    case (a)
      8'h10:   pat = 16'hBEEF;
      8'h20:   pat = 16'hCAFE;
      default: pat = {a, a ^ 8'h3C};
    endcase
  endfunction

  // Memory model, latency 1
  logic [15:0] mem1 [0:255];
  logic [15:0] rd1;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= pat(8'(i));
    end else if (mem_en) begin
      if (mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
      else        rd1 <= mem1[mem_addr[7:0]];
    end
  end
  assign mem_rdata = rd1;

  // Memory model, latency 3
  logic [15:0] mem3 [0:255];
  logic [15:0] p0, p1, p2;
  always @(posedge clk) begin
    p1 <= p0;
    p2 <= p1;
    if (!rst3) begin
      for (int i = 0; i < 256; i++) mem3[i] <= pat(8'(i));
    end else if (m3_en) begin
      if (m3_we) mem3[m3_addr[7:0]] <= m3_wdata;
      else       p0 <= mem3[m3_addr[7:0]];
    end
  end
  assign m3_rdata = p2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [15:0] rdata; } exp_t;
  typedef struct { int cyc; logic gid; logic we; logic [15:0] addr; logic [15:0] wdata; } iss_t;
  exp_t cpu_q[$];
  exp_t ld_q[$];
  iss_t iss_q[$];
  int   cpu_ack_cyc, ld_ack_cyc, c3_ack_cyc;
  int   c3_ack_cnt = 0;

  task automatic sb_cpu();
    exp_t e;
    chk("cpu_ack_expected", 32'(cpu_q.size() != 0), 32'd1);
    if (cpu_q.size() != 0) begin
      e = cpu_q.pop_front();
      chk("cpu_ack_gid", 32'(grant_id), 32'd0);
      if (!e.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
    end
  endtask

  task automatic sb_ld();
    exp_t e;
    chk("ld_ack_expected", 32'(ld_q.size() != 0), 32'd1);
    if (ld_q.size() != 0) begin
      e = ld_q.pop_front();
      chk("ld_ack_gid", 32'(grant_id), 32'd1);
      if (!e.we) chk("ld_rdata", 32'(ld_rdata), 32'(e.rdata));
    end
  endtask

  // Completion and issue monitors for the latency-1 instance
  always @(negedge clk) begin
    if (rst && cpu_ack) begin
      cpu_ack_cyc <= cyc;
      sb_cpu();
    end
    if (rst && ld_ack) begin
      ld_ack_cyc <= cyc;
      sb_ld();
    end
    if (rst && mem_en) iss_q.push_back('{cyc, grant_id, mem_we, mem_addr, mem_wdata});
  end

  // Ack monitor for the latency-3 instance
  always @(negedge clk) begin
    if (c3_ack) begin
      c3_ack_cnt <= c3_ack_cnt + 1;
      c3_ack_cyc <= cyc;
    end
  end

  task automatic cpu_access(input logic we, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [15:0] exp_rd);
    logic seen;
    seen = 1'b0;
    cpu_q.push_back('{we, exp_rd});
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_ack;
    end
    chk("cpu_ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic ld_access(input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp_rd);
    logic seen;
    seen = 1'b0;
    ld_q.push_back('{we, exp_rd});
    ld_we = we; ld_addr = addr; ld_wdata = wd; ld_req = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = ld_ack;
    end
    chk("ld_ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    ld_req = 1'b0; ld_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n0;
    logic [9:0] order;
    logic seen;

    rst = 1'b0; rst3 = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0; ld_wdata = 16'h0;
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 16'h0; c3_wdata = 16'h0;
    l3_req = 1'b0; l3_we = 1'b0; l3_addr = 16'h0; l3_wdata = 16'h0;

    // Reset with requests asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",    32'(cpu_stall), 32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_mem_en",   32'(mem_en),    32'd0);
    chk("rst_mem_addr", 32'(mem_addr),  32'd0);
    chk("rst_cpu_ack",  32'(cpu_ack),   32'd0);
    chk("rst_ld_ack",   32'(ld_ack),    32'd0);
    chk("rst_grant",    32'(grant_id),  32'd0);
    chk("rst_cpu_rd",   32'(cpu_rdata), 32'd0);
    chk("rst3_stall",   32'(c3_stall),  32'd0);
    chk("rst3_busy",    32'(busy3),     32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0; ld_req = 1'b0; c3_req = 1'b0;
    rst = 1'b1; rst3 = 1'b1;
    @(negedge clk);
    chk("rel_busy",   32'(busy),   32'd0);
    chk("rel_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;

    // Single CPU read of 0x0010
    t0 = cyc;
    fork
      cpu_access(1'b0, 16'h0010, 16'h0, 16'hBEEF);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("rd_stall", 32'(cpu_stall), 32'(i < 3));
        end
      end
    join
    chk("rd_ack_cyc",   32'(cpu_ack_cyc - t0), 32'd3);
    chk("rd_issue_cyc", 32'(iss_q[iss_q.size()-1].cyc - t0), 32'd1);
    chk("rd_issue_adr", 32'(iss_q[iss_q.size()-1].addr), 32'h10);
    chk("rd_issue_we",  32'(iss_q[iss_q.size()-1].we), 32'd0);

    // Contention: both requesters start together
    t0 = cyc;
    fork
      cpu_access(1'b0, 16'h0030, 16'h0, pat(8'h30));
      ld_access(1'b0, 16'h0040, 16'h0, pat(8'h40));
    join
    chk("cont_cpu_ack", 32'(cpu_ack_cyc - t0), 32'd3);
    chk("cont_ld_ack",  32'(ld_ack_cyc - t0),  32'd7);
    chk("cont_ld_iss",  32'(iss_q[iss_q.size()-1].cyc - t0), 32'd5);
    chk("cont_ld_gid",  32'(iss_q[iss_q.size()-1].gid), 32'd1);
    chk("cont_ld_adr",  32'(iss_q[iss_q.size()-1].addr), 32'h40);

    // Starvation guard: continuous requests from both sides
    n0 = iss_q.size();
    fork
      begin
        for (int i = 0; i < 8; i++)
          cpu_access(1'b0, 16'h0060 + 16'(i), 16'h0, pat(8'h60 + 8'(i)));
      end
      begin
        ld_access(1'b0, 16'h0050, 16'h0, pat(8'h50));
        ld_access(1'b0, 16'h0051, 16'h0, pat(8'h51));
      end
    join
    order = 10'b10_0001_0000;
    chk("starve_count", 32'(iss_q.size() - n0), 32'd10);
    if (iss_q.size() >= n0 + 10) begin
      for (int k = 0; k < 10; k++)
        chk("starve_order", 32'(iss_q[n0+k].gid), 32'(order[k]));
    end

    // Loader write then CPU read-back
    ld_access(1'b1, 16'h0005, 16'h1234, 16'h0);
    chk("wr_iss_gid",   32'(iss_q[iss_q.size()-1].gid),   32'd1);
    chk("wr_iss_we",    32'(iss_q[iss_q.size()-1].we),    32'd1);
    chk("wr_iss_wdata", 32'(iss_q[iss_q.size()-1].wdata), 32'h1234);
    chk("wr_iss_addr",  32'(iss_q[iss_q.size()-1].addr),  32'h5);
    chk("wr_ld_hold",   32'(ld_rdata), 32'(pat(8'h51)));
    cpu_access(1'b0, 16'h0005, 16'h0, 16'h1234);
    chk("rb_ld_hold",   32'(ld_rdata), 32'(pat(8'h51)));
    @(negedge clk);
    chk("idle_mem_we",    32'(mem_we),    32'd0);
    chk("idle_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;

    // Reset during the second WAIT cycle of a latency-3 access
    t0 = cyc;
    c3_we = 1'b0; c3_addr = 16'h0020; c3_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("mw_busy_before", 32'(busy3), 32'd1);
    rst3 = 1'b0;
    @(negedge clk);
    chk("mw_busy",  32'(busy3),    32'd0);
    chk("mw_stall", 32'(c3_stall), 32'd0);
    chk("mw_mem_en", 32'(m3_en),   32'd0);
    chk("mw_rdata", 32'(c3_rdata), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b1;
    chk("mw_no_ack", 32'(c3_ack_cnt), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = c3_ack;
    end
    chk("mw_ack_seen", 32'(seen), 32'd1);
    chk("mw_rdata_ok", 32'(c3_rdata), 32'hCAFE);
    @(posedge clk); #1;
    c3_req = 1'b0;
    chk("mw_ack_cyc", 32'(c3_ack_cyc - t0), 32'd10);
    chk("mw_ack_cnt", 32'(c3_ack_cnt), 32'd1);

    repeat (3) @(posedge clk);
    chk("sb_cpu_empty", 32'(cpu_q.size()), 32'd0);
    chk("sb_ld_empty",  32'(ld_q.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
